// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential N x N signed matrix multiplier:
// FSM state encoding, flat-bus element offsets and accumulator sizing.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Row-major packing with element [0][0] in the MSBs.
  function automatic int elem_lsb(int i, int j, int n, int w);
    return (n * n - 1 - (i * n + j)) * w;
  endfunction

  // Wide enough for N full-scale signed products without overflow.
  function automatic int acc_width(int n, int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac_unit.sv
// Signed multiply-accumulate with write-back narrowing to W bits.
// MATRIX_SAT_EN selects clamping write-back; otherwise two's-complement wrap.
module mac_unit #(
  parameter int W  = 32,
  parameter int AW = 2 * W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         last,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] wb,
  output logic         clamp
);

  logic signed [2*W-1:0] product;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sum;

  assign product = (2 * W)'($signed(a)) * (2 * W)'($signed(b));
  assign sum     = acc + {{(AW - 2 * W){product[2*W-1]}}, product};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end
  end

`ifdef MATRIX_SAT_EN
  logic fits;

  // The value fits in W bits when all bits from W-1 upward agree.
  assign fits = (&sum[AW-1:W-1]) | ~(|sum[AW-1:W-1]);

  always_comb begin
    wb    = sum[W-1:0];
    clamp = 1'b0;
    if (!fits) begin
      clamp = 1'b1;
      wb    = sum[AW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    end
  end
`else
  assign wb    = sum[W-1:0];
  assign clamp = 1'b0;
`endif

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential N x N signed matrix multiplier, one MAC per clock, valid/ready on
// both sides. MATRIX_SAT_EN enables saturating write-back and the sat flag.
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] res_flat,
  output logic             sat
);

  localparam int AW = acc_width(N, W);
  localparam int CW = $clog2(N);
  localparam int FW = N * N * W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state, state_nx;
  logic [FW-1:0]   a_reg, b_reg;
  logic [CW-1:0]   i, j, k;
  logic            accept, step, last_k, last_elem;
  logic [W-1:0]    a_sel, b_sel, wb;
  logic            clamp;

  assign accept    = in_valid & in_ready;
  assign step      = (state == CALC);
  assign last_k    = (k == LAST);
  assign last_elem = last_k && (j == LAST) && (i == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: if (last_elem) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: operand registers are deliberately not reset; they are only read
  // in CALC, which can only be entered through a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a_flat;
      b_reg <= b_flat;
    end
  end

  // k runs fastest, then j, then i.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (step) begin
      if (!last_k) begin
        k <= k + 1'b1;
      end else begin
        k <= '0;
        if (j != LAST) begin
          j <= j + 1'b1;
        end else begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (i == CW'(r) && k == CW'(c)) a_sel = a_reg[elem_lsb(r, c, N, W) +: W];
        if (k == CW'(r) && j == CW'(c)) b_sel = b_reg[elem_lsb(r, c, N, W) +: W];
      end
    end
  end

  mac_unit #(
    .W (W),
    .AW(AW)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .en   (step),
    .last (last_k),
    .a    (a_sel),
    .b    (b_sel),
    .wb   (wb),
    .clamp(clamp)
  );

  // Elements not yet rewritten keep the previous result until overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_flat <= '0;
    end else if (step && last_k) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (i == CW'(r) && j == CW'(c)) res_flat[elem_lsb(r, c, N, W) +: W] <= wb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || accept) sat <= 1'b0;
    else if (step && last_k && clamp) sat <= 1'b1;
  end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: N=2/W=32 and N=3/W=16 instances
// against a plain-arithmetic matrix product model (honours MATRIX_SAT_EN).
module tb_matrix_mult_seq;

  typedef logic signed [63:0] elem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic         in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic         in_ready0, out_valid0, sat0;
  logic [127:0] a0 = '0, b0 = '0, res0;

  logic         in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic         in_ready1, out_valid1, sat1;
  logic [143:0] a1 = '0, b1 = '0, res1;

  int vectors = 0;
  int miscompares = 0;

  matrix_mult_seq #(.N(2), .W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_flat(a0), .b_flat(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .res_flat(res0), .sat(sat0)
  );

  matrix_mult_seq #(.N(3), .W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_flat(a1), .b_flat(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .res_flat(res1), .sat(sat1)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input int n, input int w, input elem_t m[9]);
    logic [255:0] f;
    f = '0;
    for (int idx = 0; idx < n * n; idx++)
      for (int bt = 0; bt < w; bt++) f[(n * n - 1 - idx) * w + bt] = m[idx][bt];
    return f;
  endfunction

  // Reference: textbook triple loop with wide exact sums, then W-bit write-back.
  task automatic ref_mult(input int n, input int w, input elem_t a[9], input elem_t b[9],
                          output logic [255:0] flat, output logic s);
    logic signed [127:0] sum, maxv, minv;
    elem_t r;
    flat = '0;
    s    = 1'b0;
    maxv = (128'sd1 <<< (w - 1)) - 128'sd1;
    minv = -(128'sd1 <<< (w - 1));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        sum = '0;
        for (int k = 0; k < n; k++) sum = sum + a[i * n + k] * b[k * n + j];
        r = sum[63:0];
`ifdef MATRIX_SAT_EN
        if (sum > maxv) begin
          r = maxv[63:0];
          s = 1'b1;
        end else if (sum < minv) begin
          r = minv[63:0];
          s = 1'b1;
        end
`endif
        for (int bt = 0; bt < w; bt++) flat[(n * n - 1 - (i * n + j)) * w + bt] = r[bt];
      end
    end
  endtask

  task automatic rand_mat(input int n, input int w, output elem_t m[9]);
    logic [31:0] r;
    for (int idx = 0; idx < 9; idx++) begin
      r = $urandom;
      if (idx >= n * n) m[idx] = '0;
      else if (w == 32) m[idx] = $signed(r);
      else m[idx] = $signed(r[15:0]);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? in_ready1 : in_ready0;
  endfunction

  function automatic logic ovld(input int sel);
    return (sel != 0) ? out_valid1 : out_valid0;
  endfunction

  function automatic logic [255:0] res_of(input int sel);
    return (sel != 0) ? 256'(res1) : 256'(res0);
  endfunction

  function automatic logic sat_of(input int sel);
    return (sel != 0) ? sat1 : sat0;
  endfunction

  task automatic drive_ops(input int sel, input logic [255:0] fa, input logic [255:0] fb,
                           input logic v);
    if (sel != 0) begin
      a1 = fa[143:0];
      b1 = fb[143:0];
      in_valid1 = v;
    end else begin
      a0 = fa[127:0];
      b0 = fb[127:0];
      in_valid0 = v;
    end
  endtask

  // Issue one operation, wait for out_valid and check latency, result and sat.
  // The result is left pending in DONE (out_ready low).
  task automatic run_op(input int sel, input elem_t ma[9], input elem_t mb[9], input bit noise,
                        input string tag, output logic [255:0] exp);
    int n, w, lat;
    logic s;
    n = (sel != 0) ? 3 : 2;
    w = (sel != 0) ? 16 : 32;
    ref_mult(n, w, ma, mb, exp, s);
    @(negedge clk);
    check({tag, "_in_ready"}, 256'(rdy(sel)), 256'(1));
    drive_ops(sel, pack(n, w, ma), pack(n, w, mb), 1'b1);
    @(posedge clk);
    #1;
    drive_ops(sel, '0, '0, 1'b0);
    lat = 0;
    while (!ovld(sel) && lat < 200) begin
      if (noise) drive_ops(sel, {8{$urandom}}, {8{$urandom}}, lat[0]);
      @(posedge clk);
      #1;
      lat++;
      if (noise && lat == 2) check({tag, "_busy_in_ready"}, 256'(rdy(sel)), 256'(0));
    end
    drive_ops(sel, '0, '0, 1'b0);
    check({tag, "_latency"}, 256'(lat), 256'(n * n * n));
    check({tag, "_res"}, res_of(sel), exp);
    check({tag, "_sat"}, 256'(sat_of(sel)), 256'(s));
  endtask

  task automatic release_op(input int sel, input string tag);
    if (sel != 0) out_ready1 = 1'b1;
    else out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    check({tag, "_rel_out_valid"}, 256'(ovld(sel)), 256'(0));
    check({tag, "_rel_in_ready"}, 256'(rdy(sel)), 256'(1));
  endtask

  initial begin
    elem_t ma[9], mb[9];
    logic [255:0] exp, held;
    int acc_cyc[$];
    int cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready0", 256'(in_ready0), 256'(1));
    check("rst_out_valid0", 256'(out_valid0), 256'(0));
    check("rst_res0", 256'(res0), 256'(0));
    check("rst_sat0", 256'(sat0), 256'(0));
    check("rst_in_ready1", 256'(in_ready1), 256'(1));
    check("rst_res1", 256'(res1), 256'(0));
    rst_n = 1'b1;

    // Basic 2x2 product
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_op(0, ma, mb, 1'b0, "basic", exp);
    check("basic_const", exp, 256'({32'd19, 32'd22, 32'd43, 32'd50}));
    release_op(0, "basic");

    // Signed operands
    ma = '{-1, 0, 0, -1, 0, 0, 0, 0, 0};
    mb = '{5, -6, 7, 8, 0, 0, 0, 0, 0};
    run_op(0, ma, mb, 1'b0, "signed", exp);
    release_op(0, "signed");

    // Overflow: wrap to 0xFFFFFFFC, or clamp to 0x7FFFFFFF with sat
    ma = '{64'sh7FFFFFFF, 64'sh7FFFFFFF, 64'sh7FFFFFFF, 64'sh7FFFFFFF, 0, 0, 0, 0, 0};
    mb = '{2, 2, 2, 2, 0, 0, 0, 0, 0};
    run_op(0, ma, mb, 1'b0, "ovf", exp);
    release_op(0, "ovf");

    // Negative overflow
    ma = '{-64'sh80000000, -64'sh80000000, 0, 0, 0, 0, 0, 0, 0};
    mb = '{64'sh7FFFFFFF, 1, 64'sh7FFFFFFF, 1, 0, 0, 0, 0, 0};
    run_op(0, ma, mb, 1'b0, "novf", exp);
    release_op(0, "novf");

    // Backpressure with busy input noise during CALC
    rand_mat(2, 32, ma);
    rand_mat(2, 32, mb);
    run_op(0, ma, mb, 1'b1, "bp", held);
    for (int c = 0; c < 5; c++) begin
      drive_ops(0, {8{$urandom}}, {8{$urandom}}, 1'b1);
      @(posedge clk);
      #1;
      check("bp_out_valid", 256'(out_valid0), 256'(1));
      check("bp_res_hold", 256'(res0), held);
      check("bp_in_ready", 256'(in_ready0), 256'(0));
    end
    drive_ops(0, '0, '0, 1'b0);
    release_op(0, "bp");
    check("bp_res_after", 256'(res0), held);

    // Reset in the middle of CALC
    rand_mat(2, 32, ma);
    rand_mat(2, 32, mb);
    @(negedge clk);
    drive_ops(0, pack(2, 32, ma), pack(2, 32, mb), 1'b1);
    @(posedge clk);
    #1;
    drive_ops(0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_busy", 256'(in_ready0), 256'(0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 256'(out_valid0), 256'(0));
    check("midrst_res", 256'(res0), 256'(0));
    check("midrst_in_ready", 256'(in_ready0), 256'(1));
    check("midrst_sat", 256'(sat0), 256'(0));
    rand_mat(2, 32, ma);
    rand_mat(2, 32, mb);
    run_op(0, ma, mb, 1'b0, "postrst", exp);
    release_op(0, "postrst");

    // Random 2x2
    for (int t = 0; t < 4; t++) begin
      rand_mat(2, 32, ma);
      rand_mat(2, 32, mb);
      run_op(0, ma, mb, 1'b0, "rand2", exp);
      release_op(0, "rand2");
    end

    // 3x3 identity times B = B
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_op(1, ma, mb, 1'b0, "ident3", exp);
    check("ident3_eq_b", 256'(res1), pack(3, 16, mb));
    release_op(1, "ident3");

    for (int t = 0; t < 2; t++) begin
      rand_mat(3, 16, ma);
      rand_mat(3, 16, mb);
      run_op(1, ma, mb, 1'b0, "rand3", exp);
      release_op(1, "rand3");
    end

    // Back-to-back spacing with no backpressure
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    @(negedge clk);
    drive_ops(1, pack(3, 16, ma), pack(3, 16, mb), 1'b1);
    out_ready1 = 1'b1;
    cyc = 0;
    while (acc_cyc.size() < 2 && cyc < 200) begin
      if (in_ready1) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      cyc++;
    end
    drive_ops(1, '0, '0, 1'b0);
    out_ready1 = 1'b0;
    check("b2b_count", 256'(acc_cyc.size()), 256'(2));
    if (acc_cyc.size() == 2) check("b2b_spacing", 256'(acc_cyc[1] - acc_cyc[0]), 256'(29));
    cyc = 0;
    while (!out_valid1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("b2b_res", 256'(res1), pack(3, 16, mb));
    release_op(1, "b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
